entrada_notas: RTL and testbench

ENTRADA_NOTAS -- requirements
Module: entrada_notas

---
 rtl/entrada_notas.sv | 198 +++++++++++++++++++
 tb/tb_entrada_notas.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/entrada_notas.sv
// entrada_notas: note-entry front end for the word classifier.
// Synchronizes and debounces the ok push-button and captures the note
// switches on each accepted press. It emits a fixed-width ok pulse and counts
// the captured notes. Entry stops after a null note or the fifth note.
// Optional feature macro: NOTE_ECHO_EN. When defined, display echoes
// nota[2:0] as an active-low gfedcba digit. When undefined, display is
// tied high.
module entrada_notas #(
    parameter int DEB_CYCLES   = 16,
    parameter int PULSE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ok,
    input  logic [3:0] sw_nota,
    output logic       ok,
    output logic [3:0] nota,
    output logic [2:0] qtd,
    output logic       cheio,
    output logic [6:0] display
);

    // One counter is shared by the press/release debounce and the pulse timer.
    localparam int CMAX = (DEB_CYCLES > PULSE_CYCLES) ? DEB_CYCLES : PULSE_CYCLES;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [2:0]    QTD_MAX    = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS    = 3'd1,
        EMIT     = 3'd2,
        WAIT_REL = 3'd3,
        RELEASE  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ok_q, ok_d;
    logic [3:0]    nota_q, nota_d;
    logic [2:0]    qtd_q, qtd_d;
    logic          cheio_q, cheio_d;

    logic          btn_meta_q, btn_s_q;
    logic [3:0]    nota_meta_q, nota_s_q;
    logic          end_of_word;

`ifdef NOTE_ECHO_EN
    logic [6:0]    display_q, display_d;

    // Active-low gfedcba code for digits 0-7.
    function automatic logic [6:0] seg7(input logic [2:0] d);
        case (d)
            3'd0:    seg7 = 7'b1000000;
            3'd1:    seg7 = 7'b1111001;
            3'd2:    seg7 = 7'b0100100;
            3'd3:    seg7 = 7'b0110000;
            3'd4:    seg7 = 7'b0011001;
            3'd5:    seg7 = 7'b0010010;
            3'd6:    seg7 = 7'b0000010;
            default: seg7 = 7'b1111000;
        endcase
    endfunction
`endif

    // Two-flop synchronizers for the asynchronous button and switches.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
            nota_meta_q <= 4'b0000;
            nota_s_q    <= 4'b0000;
        end else begin
            btn_meta_q  <= btn_ok;
            btn_s_q     <= btn_meta_q;
            nota_meta_q <= sw_nota;
            nota_s_q    <= nota_meta_q;
        end
    end

    // A null note (x000) or a full word ends entry.
    assign end_of_word = (nota_q[2:0] == 3'b000) || (qtd_q == QTD_MAX);

    // Next-state logic. ok is decided here and registered, so it is glitch-free.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ok_d      = 1'b0;
        nota_d    = nota_q;
        qtd_d     = qtd_q;
        cheio_d   = cheio_q;
`ifdef NOTE_ECHO_EN
        display_d = display_q;
`endif
        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = EMIT;
                    cnt_d     = '0;
                    ok_d      = 1'b1;
                    nota_d    = nota_s_q;
                    qtd_d     = (qtd_q >= QTD_MAX) ? QTD_MAX : qtd_q + 3'd1;
`ifdef NOTE_ECHO_EN
                    display_d = seg7(nota_s_q[2:0]);
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EMIT: begin
                // The button level is ignored while the pulse is out.
                if (cnt_q == PULSE_LAST) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    ok_d  = 1'b1;
                end
            end
            WAIT_REL: begin
                if (!btn_s_q) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (btn_s_q) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d = '0;
                    if (end_of_word) begin
                        state_d = DONE;
                        cheio_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                cheio_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers. Reset overrides everything, including a live pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ok_q      <= 1'b0;
            nota_q    <= 4'b0000;
            qtd_q     <= 3'd0;
            cheio_q   <= 1'b0;
`ifdef NOTE_ECHO_EN
            display_q <= 7'b1111111;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ok_q      <= ok_d;
            nota_q    <= nota_d;
            qtd_q     <= qtd_d;
            cheio_q   <= cheio_d;
`ifdef NOTE_ECHO_EN
            display_q <= display_d;
`endif
        end
    end

    assign ok    = ok_q;
    assign nota  = nota_q;
    assign qtd   = qtd_q;
    assign cheio = cheio_q;
`ifdef NOTE_ECHO_EN
    assign display = display_q;
`else
    assign display = 7'b1111111;
`endif

endmodule

// File: tb/tb_entrada_notas.sv
// Scoreboard bench for entrada_notas with DEB_CYCLES=4 and PULSE_CYCLES=2.
// Stimulus pushes the expected {nota, qtd} of each ok pulse. The monitor pops
// an entry on every rising ok and also checks the pulse width.
module tb_entrada_notas;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_ok;
    logic [3:0] sw_nota;
    logic       ok;
    logic [3:0] nota;
    logic [2:0] qtd;
    logic       cheio;
    logic [6:0] display;

    typedef struct {
        logic [3:0] n;
        logic [2:0] q;
    } exp_t;

    exp_t q_exp[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_qtd = 0;

    entrada_notas #(.DEB_CYCLES(4), .PULSE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .btn_ok(btn_ok), .sw_nota(sw_nota),
        .ok(ok), .nota(nota), .qtd(qtd), .cheio(cheio), .display(display)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected display for a captured note.
    function automatic int exp_disp(input logic [3:0] n);
`ifdef NOTE_ECHO_EN
        logic [6:0] tbl [8];
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
        tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
        tbl[6] = 7'b0000010; tbl[7] = 7'b1111000;
        return int'(tbl[n[2:0]]);
`else
        return (n == n) ? 7'b1111111 : 0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press, hold, wiggle the switches after the capture, then release.
    task automatic press(input logic [3:0] n, input bit counted);
        sw_nota = n;
        btn_ok  = 1'b1;
        if (counted) begin
            exp_qtd++;
            q_exp.push_back('{n, 3'(exp_qtd)});
        end
        tick(12);
        sw_nota = ~n;
        tick(2);
        if (counted) chk("nota_hold", nota, n);
        btn_ok = 1'b0;
        tick(10);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        exp_qtd = 0;
        tick(1);
    endtask

    // Monitor: compare each pulse against the scoreboard and time its width.
    logic ok_prev = 1'b0;
    int   width = 0;
    bit   abort = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (ok && !ok_prev) begin
            if (q_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ok: got ok=1 expected no pulse at %0t", $time);
            end else begin
                e = q_exp.pop_front();
                chk("pulse_nota", nota, e.n);
                chk("pulse_qtd", qtd, e.q);
            end
            width = 1;
            abort = !reset;
        end else if (ok) begin
            width++;
            if (!reset) abort = 1'b1;
        end else if (ok_prev && !abort) begin
            chk("pulse_width", width, 2);
        end
        ok_prev = ok;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        btn_ok  = 1'b0;
        sw_nota = 4'b0000;
        tick(3);
        chk("rst_ok", ok, 0);
        chk("rst_nota", nota, 0);
        chk("rst_qtd", qtd, 0);
        chk("rst_cheio", cheio, 0);
        chk("rst_display", display, 7'b1111111);
        reset = 1'b1;
        tick(2);

        // Clean press: ok rises on edge 6 and lasts two cycles.
        sw_nota = 4'b0110;
        btn_ok  = 1'b1;
        exp_qtd = 1;
        q_exp.push_back('{4'b0110, 3'd1});
        tick(6);
        chk("lat_ok_e5", ok, 0);
        chk("lat_nota_e5", nota, 0);
        tick(1);
        chk("lat_ok_e6", ok, 1);
        chk("lat_nota_e6", nota, 4'b0110);
        chk("lat_qtd_e6", qtd, 1);
        tick(1);
        chk("lat_ok_e7", ok, 1);
        tick(1);
        chk("lat_ok_e8", ok, 0);
        tick(11);
        btn_ok = 1'b0;
        tick(10);
        chk("clean_cheio", cheio, 0);

        // Bouncing press 1-0-1: one pulse, timed from the last rise.
        sw_nota = 4'b0010;
        btn_ok  = 1'b1;
        tick(1);
        btn_ok  = 1'b0;
        tick(1);
        btn_ok  = 1'b1;
        exp_qtd = 2;
        q_exp.push_back('{4'b0010, 3'd2});
        tick(6);
        chk("bounce_ok_e5", ok, 0);
        tick(1);
        chk("bounce_ok_e6", ok, 1);
        tick(12);
        btn_ok = 1'b0;
        tick(10);
        chk("bounce_qtd", qtd, 2);

        press(4'b0101, 1'b1);
        chk("disp_0101", display, exp_disp(4'b0101));
        do_reset();
        chk("rst2_qtd", qtd, 0);
        chk("rst2_display", display, 7'b1111111);

        // Five non-null notes fill the word; a sixth press is ignored.
        press(4'b0001, 1'b1);
        press(4'b0010, 1'b1);
        press(4'b0110, 1'b1);
        press(4'b1111, 1'b1);
        chk("four_cheio", cheio, 0);
        chk("four_qtd", qtd, 4);
        press(4'b0001, 1'b1);
        chk("five_cheio", cheio, 1);
        chk("five_qtd", qtd, 5);
        press(4'b0011, 1'b0);
        chk("six_qtd", qtd, 5);
        chk("six_nota", nota, 4'b0001);
        chk("six_cheio", cheio, 1);
        do_reset();

        // A null note (1000) ends the word early.
        press(4'b0011, 1'b1);
        press(4'b0100, 1'b1);
        chk("null_pre_cheio", cheio, 0);
        press(4'b1000, 1'b1);
        chk("null_nota", nota, 4'b1000);
        chk("null_cheio", cheio, 1);
        chk("null_qtd", qtd, 3);
        chk("null_display", display, exp_disp(4'b1000));
        do_reset();

        // Reset during the first EMIT cycle kills the pulse; a held button re-debounces.
        sw_nota = 4'b0111;
        btn_ok  = 1'b1;
        q_exp.push_back('{4'b0111, 3'd1});
        tick(7);
        chk("emit_ok", ok, 1);
        reset = 1'b0;
        tick(1);
        chk("emitrst_ok", ok, 0);
        chk("emitrst_nota", nota, 0);
        chk("emitrst_qtd", qtd, 0);
        chk("emitrst_display", display, 7'b1111111);
        reset = 1'b1;
        q_exp.push_back('{4'b0111, 3'd1});
        tick(6);
        chk("redeb_ok_e5", ok, 0);
        tick(1);
        chk("redeb_ok_e6", ok, 1);
        chk("redeb_nota", nota, 4'b0111);
        chk("redeb_qtd", qtd, 1);
        tick(4);
        btn_ok = 1'b0;
        tick(10);

        chk("scoreboard_empty", q_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
